// File: rtl/regfile_scoreboard.sv
// Architectural register file with per-register in-flight counters and a decode stall.
// Optional same-cycle write-back bypass: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              writeReg_w,
  input  logic [ADDR_W-1:0] dst_w,
  input  logic [DATA_W-1:0] regData_w,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  input  logic              useA,
  input  logic              useB,
  output logic [DATA_W-1:0] rdDataA,
  output logic [DATA_W-1:0] rdDataB,
  input  logic              issue_d,
  input  logic [ADDR_W-1:0] issueDst_d,
  output logic              stall_d,
  output logic              sbErr
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] mem [NREG];
  logic [CNT_W-1:0]  cnt [NREG];

  logic            busy_a;
  logic            busy_b;
  logic            accept;
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;

  always_comb begin
    rdDataA = mem[rdAddrA];
    rdDataB = mem[rdAddrB];
    busy_a  = cnt[rdAddrA] != '0;
    busy_b  = cnt[rdAddrB] != '0;
`ifdef REGFILE_BYPASS_EN
    // The presented write-back retires one in-flight write: busy means cnt-1 != 0,
    // and a zero count (spurious write-back) stays not busy rather than wrapping.
    if (writeReg_w && (dst_w == rdAddrA)) begin
      rdDataA = regData_w;
      busy_a  = cnt[rdAddrA] > CNT_ONE;
    end
    if (writeReg_w && (dst_w == rdAddrB)) begin
      rdDataB = regData_w;
      busy_b  = cnt[rdAddrB] > CNT_ONE;
    end
`endif
  end

  assign stall_d = (useA && busy_a) || (useB && busy_b) ||
                   (issue_d && (cnt[issueDst_d] == CNT_MAX));

  assign accept = issue_d && !stall_d;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      inc[r] = accept && (issueDst_d == ADDR_W'(r));
      dec[r] = writeReg_w && (dst_w == ADDR_W'(r)) && (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        mem[r] <= '0;
        cnt[r] <= '0;
      end
      sbErr <= 1'b0;
    end else begin
      if (writeReg_w) begin
        mem[dst_w] <= regData_w;
        if (cnt[dst_w] == '0)
          sbErr <= 1'b1;
      end
      for (int unsigned r = 0; r < NREG; r++) begin
        if (inc[r] && !dec[r])
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec[r] && !inc[r])
          cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end

endmodule
